// File: rtl/panel_ctrl_if.sv
// Front-panel signal bundle between the key/halt sources and the panel controller.
// master = panel controller side, slave = keys/CPU/memory side.
interface panel_ctrl_if;
  logic       key_mode;
  logic       key_step;
  logic       halt;
  logic [1:0] cpustate;
  logic       step_n;
  logic [5:0] load_cnt;
  logic       full;
  logic       run_start;
  logic       cpu_rst_n;

  modport master (
    input  key_mode, key_step, halt,
    output cpustate, step_n, load_cnt, full, run_start, cpu_rst_n
  );

  modport slave (
    output key_mode, key_step, halt,
    input  cpustate, step_n, load_cnt, full, run_start, cpu_rst_n
  );
endinterface

// File: rtl/panel_ctrl.sv
// Front-panel controller: key debounce, CPU mode FSM, step strobe and load counting.
// Optional macro PANEL_LOAD_GUARD_EN: CHECK -> RUN only when at least one word was loaded.
module panel_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int MEM_WORDS  = 32
) (
  input  logic          clk,
  input  logic          reset,
  panel_ctrl_if.master  pif
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [5:0]       LOAD_MAX = 6'(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IN    = 2'b01,
    ST_CHECK = 2'b10,
    ST_RUN   = 2'b11
  } state_t;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v >= LOAD_MAX) ? LOAD_MAX : v + 6'd1;
  endfunction

  // Bit 0 = mode key, bit 1 = step key; all key levels are active-low.
  logic [1:0]       key_raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       deb_p2;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       settle;
  logic [1:0]       press;

  assign key_raw = {pif.key_step, pif.key_mode};

  // Stage p0/p1: two-flop synchronizer; stage p2: stability counter and debounced level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      deb_p2  <= 2'b11;
      for (int k = 0; k < 2; k++) cnt[k] <= '0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      for (int k = 0; k < 2; k++) begin
        if (sync_p1[k] == deb_p2[k]) begin
          cnt[k] <= '0;
        end else if (settle[k]) begin
          deb_p2[k] <= sync_p1[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // The press event is the cycle on which the debounced level is about to fall.
  always_comb begin
    settle = '0;
    press  = '0;
    for (int k = 0; k < 2; k++) begin
      settle[k] = (sync_p1[k] != deb_p2[k]) && (cnt[k] == CNT_MAX);
      press[k]  = settle[k] && !sync_p1[k];
    end
  end

  logic mode_press;
  logic step_press;
  assign mode_press = press[0];
  assign step_press = press[1];

  state_t     state;
  logic [5:0] load_cnt_q;
  logic       full_q;
  logic       step_n_q;
  logic       run_start_q;
  logic       cpu_rst_n_q;

  // Mode FSM with registered outputs; halt outranks a coincident mode press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      load_cnt_q  <= 6'd0;
      full_q      <= 1'b0;
      step_n_q    <= 1'b1;
      run_start_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      step_n_q    <= 1'b1;
      run_start_q <= 1'b0;
      if (state == ST_RUN && pif.halt) begin
        state       <= ST_IDLE;
        cpu_rst_n_q <= 1'b0;
      end else if (mode_press) begin
        case (state)
          ST_IDLE: begin
            state      <= ST_IN;
            load_cnt_q <= 6'd0;
            full_q     <= 1'b0;
          end
          ST_IN: state <= ST_CHECK;
          ST_CHECK: begin
`ifdef PANEL_LOAD_GUARD_EN
            if (load_cnt_q == 6'd0) begin
              state <= ST_IDLE;
            end else begin
              state       <= ST_RUN;
              run_start_q <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end
`else
            state       <= ST_RUN;
            run_start_q <= 1'b1;
            cpu_rst_n_q <= 1'b1;
`endif
          end
          ST_RUN: begin
            state       <= ST_IDLE;
            cpu_rst_n_q <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (step_press) begin
        // Presses in IDLE, RUN or a full IN session are dropped, not queued.
        if (state == ST_IN && !full_q) begin
          step_n_q   <= 1'b0;
          load_cnt_q <= sat_inc(load_cnt_q);
          full_q     <= (sat_inc(load_cnt_q) == LOAD_MAX);
        end else if (state == ST_CHECK) begin
          step_n_q <= 1'b0;
        end
      end
    end
  end

  assign pif.cpustate  = state;
  assign pif.step_n    = step_n_q;
  assign pif.load_cnt  = load_cnt_q;
  assign pif.full      = full_q;
  assign pif.run_start = run_start_q;
  assign pif.cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_panel_ctrl.sv
// Bench for panel_ctrl: directed front-panel scenarios plus random key/halt/reset
// traffic, compared every cycle against a sample-window reference model.
module tb_panel_ctrl;
  localparam int DEB  = 4;
  localparam int MEMW = 32;
  localparam int HL   = DEB + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  panel_ctrl_if pif();

  panel_ctrl #(.DEB_CYCLES(DEB), .MEM_WORDS(MEMW)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a key level is accepted once the raw samples taken 2..DEB+1
  // edges ago all agree and differ from the accepted level.
  int hm [HL];
  int hs [HL];
  int m_deb_mode = 1, m_deb_step = 1;
  int m_state = 0, m_load = 0, m_step_n = 1, m_run_start = 0;

  always @(posedge clk or negedge reset) begin : ref_model
    int all0m, all1m, all0s, all1s;
    bit mp, sp;
    if (!reset) begin
      for (int k = 0; k < HL; k++) begin
        hm[k] = 1;
        hs[k] = 1;
      end
      m_deb_mode = 1; m_deb_step = 1;
      m_state = 0; m_load = 0; m_step_n = 1; m_run_start = 0;
    end else begin
      for (int k = HL - 1; k > 0; k--) begin
        hm[k] = hm[k-1];
        hs[k] = hs[k-1];
      end
      hm[0] = int'(pif.key_mode);
      hs[0] = int'(pif.key_step);
      all0m = 1; all1m = 1; all0s = 1; all1s = 1;
      for (int k = 2; k < HL; k++) begin
        if (hm[k] != 0) all0m = 0;
        if (hm[k] != 1) all1m = 0;
        if (hs[k] != 0) all0s = 0;
        if (hs[k] != 1) all1s = 0;
      end
      mp = (m_deb_mode == 1) && (all0m == 1);
      sp = (m_deb_step == 1) && (all0s == 1);
      if (mp) m_deb_mode = 0; else if (m_deb_mode == 0 && all1m == 1) m_deb_mode = 1;
      if (sp) m_deb_step = 0; else if (m_deb_step == 0 && all1s == 1) m_deb_step = 1;

      m_step_n = 1;
      m_run_start = 0;
      if (m_state == 3 && pif.halt) begin
        m_state = 0;
      end else if (mp) begin
        case (m_state)
          0: begin m_state = 1; m_load = 0; end
          1: m_state = 2;
`ifdef PANEL_LOAD_GUARD_EN
          2: m_state = (m_load == 0) ? 0 : 3;
`else
          2: m_state = 3;
`endif
          default: m_state = 0;
        endcase
        m_run_start = (m_state == 3) ? 1 : 0;
      end else if (sp) begin
        if (m_state == 1 && m_load < MEMW) begin
          m_load++;
          m_step_n = 0;
        end else if (m_state == 2) begin
          m_step_n = 0;
        end
      end
    end
  end

  int step_pulses = 0;
  int rs_pulses   = 0;

  always @(negedge clk) begin
    check_val("cpustate",  int'(pif.cpustate),  m_state);
    check_val("step_n",    int'(pif.step_n),    m_step_n);
    check_val("load_cnt",  int'(pif.load_cnt),  m_load);
    check_val("full",      int'(pif.full),      (m_load == MEMW) ? 1 : 0);
    check_val("run_start", int'(pif.run_start), m_run_start);
    check_val("cpu_rst_n", int'(pif.cpu_rst_n), (m_state == 3) ? 1 : 0);
    if (reset && !pif.step_n)   step_pulses++;
    if (reset && pif.run_start) rs_pulses++;
  end

  // sel bit0 = mode key, bit1 = step key; pressed together on the same cycle.
  task automatic key_press(input int sel, input int len);
    @(negedge clk);
    if (sel[0]) pif.key_mode = 1'b0;
    if (sel[1]) pif.key_step = 1'b0;
    repeat (len) @(negedge clk);
    pif.key_mode = 1'b1;
    pif.key_step = 1'b1;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic halt_pulse();
    @(negedge clk);
    pif.halt = 1'b1;
    @(negedge clk);
    pif.halt = 1'b0;
  endtask

  int p0, r0;

  initial begin
    pif.key_mode = 1'b1;
    pif.key_step = 1'b1;
    pif.halt     = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    repeat (100) @(negedge clk);
    check_val("rst_cpustate",  int'(pif.cpustate),  0);
    check_val("rst_step_n",    int'(pif.step_n),    1);
    check_val("rst_cpu_rst_n", int'(pif.cpu_rst_n), 0);
    check_val("rst_load_cnt",  int'(pif.load_cnt),  0);

    // 3-cycle glitch must be ignored
    pif.key_mode = 1'b0;
    repeat (3) @(negedge clk);
    pif.key_mode = 1'b1;
    repeat (12) @(negedge clk);
    check_val("glitch_state", int'(pif.cpustate), 0);

    // Clean 20-cycle press: transition lands exactly 2+DEB edges after the fall
    pif.key_mode = 1'b0;
    repeat (DEB + 1) @(negedge clk);
    check_val("lat_before", int'(pif.cpustate), 0);
    @(negedge clk);
    check_val("lat_exact", int'(pif.cpustate), 1);
    repeat (20 - DEB - 2) @(negedge clk);
    pif.key_mode = 1'b1;
    repeat (12) @(negedge clk);
    check_val("one_transition", int'(pif.cpustate), 1);

    p0 = step_pulses;
    repeat (MEMW + 1) key_press(2, 6);
    check_val("in_pulses", step_pulses - p0, MEMW);
    check_val("in_load",   int'(pif.load_cnt), MEMW);
    check_val("in_full",   int'(pif.full), 1);

    key_press(1, 6);
    check_val("to_check", int'(pif.cpustate), 2);
    p0 = step_pulses;
    repeat (3) key_press(2, 6);
    check_val("check_pulses", step_pulses - p0, 3);
    check_val("check_load",   int'(pif.load_cnt), MEMW);

    r0 = rs_pulses;
    key_press(1, 6);
    check_val("to_run",       int'(pif.cpustate), 3);
    check_val("run_start_n",  rs_pulses - r0, 1);
    check_val("run_cpu_rst",  int'(pif.cpu_rst_n), 1);
    @(negedge clk);
    pif.halt = 1'b1;
    @(negedge clk);
    check_val("halt_state",   int'(pif.cpustate), 0);
    check_val("halt_cpu_rst", int'(pif.cpu_rst_n), 0);
    pif.halt = 1'b0;

    // Coincident mode and step presses in IN: mode wins, step dropped
    key_press(1, 6);
    p0 = step_pulses;
    key_press(3, 6);
    check_val("coinc_state",  int'(pif.cpustate), 2);
    check_val("coinc_pulses", step_pulses - p0, 0);

    // Asynchronous reset in the middle of a step press
    pif.key_step = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("arst_cpustate",  int'(pif.cpustate),  0);
    check_val("arst_step_n",    int'(pif.step_n),    1);
    check_val("arst_load",      int'(pif.load_cnt),  0);
    check_val("arst_full",      int'(pif.full),      0);
    check_val("arst_run_start", int'(pif.run_start), 0);
    check_val("arst_cpu_rst_n", int'(pif.cpu_rst_n), 0);
    @(negedge clk);
    reset = 1'b1;
    pif.key_step = 1'b1;
    repeat (12) @(negedge clk);

    // Empty program through CHECK
    key_press(1, 6);
    key_press(1, 6);
    key_press(1, 6);
`ifdef PANEL_LOAD_GUARD_EN
    check_val("guard_empty", int'(pif.cpustate), 0);
`else
    check_val("guard_empty", int'(pif.cpustate), 3);
`endif
    halt_pulse();
    key_press(1, 6);
    key_press(2, 6);
    key_press(1, 6);
    key_press(1, 6);
    check_val("guard_one", int'(pif.cpustate), 3);
    halt_pulse();

    // Random key levels, halt and occasional mid-cycle resets
    for (int i = 0; i < 700; i++) begin
      pif.key_mode = 1'($urandom_range(0, 1));
      pif.key_step = 1'($urandom_range(0, 1));
      pif.halt     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    pif.key_mode = 1'b1;
    pif.key_step = 1'b1;
    pif.halt     = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
